// File: rtl/uart_tx_top.sv
// Packet UART transmitter: sends cmd/addr/data bytes as back-to-back 8N1 frames.
// Define UART_TX_CHKSUM_EN to append a sixth byte holding the XOR of the five packet bytes.
module uart_tx_top #(
  parameter int DVSR    = 22,
  parameter int SB_TICK = 16
) (
  input  logic       clk40M,
  input  logic       rst,
  input  logic       rspUpdate,
  input  logic [7:0] i_cmd,
  input  logic [7:0] i_addrLsb,
  input  logic [7:0] i_addrMsb,
  input  logic [7:0] i_dataLsb,
  input  logic [7:0] i_dataMsb,
  output logic       uart_tx,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

`ifdef UART_TX_CHKSUM_EN
  localparam int NBYTES = 6;
`else
  localparam int NBYTES = 5;
`endif
  localparam int TW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int SW = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [TW-1:0]   tick_cnt, tick_cnt_n;
  logic [SW-1:0]   s_cnt, s_cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [2:0]      byte_idx, byte_idx_n;
  logic [7:0]      pkt [NBYTES];
  logic            tick, bit_end, accept, last_stop;
  logic            tx_d, busy_d, done_d;

  assign tick    = (tick_cnt == TW'(DVSR - 1));
  assign bit_end = tick && (s_cnt == SW'(SB_TICK - 1));
  assign accept  = (state == IDLE) && rspUpdate;

  // State and output registers
  always_ff @(posedge clk40M) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      s_cnt    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      s_cnt    <= s_cnt_n;
      bit_idx  <= bit_idx_n;
      byte_idx <= byte_idx_n;
      uart_tx  <= tx_d;
      busy     <= busy_d;
      done     <= done_d;
      overrun  <= overrun | (rspUpdate && (state != IDLE));
    end
  end

  // Packet bytes are captured only at acceptance and held for the whole packet
  always_ff @(posedge clk40M) begin
    if (!rst && accept) begin
      pkt[0] <= i_cmd;
      pkt[1] <= i_addrLsb;
      pkt[2] <= i_addrMsb;
      pkt[3] <= i_dataLsb;
      pkt[4] <= i_dataMsb;
`ifdef UART_TX_CHKSUM_EN
      pkt[5] <= i_cmd ^ i_addrLsb ^ i_addrMsb ^ i_dataLsb ^ i_dataMsb;
`endif
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    s_cnt_n    = s_cnt;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    last_stop  = 1'b0;
    if (state == IDLE) begin
      tick_cnt_n = '0;
      s_cnt_n    = '0;
      bit_idx_n  = '0;
      byte_idx_n = '0;
      if (rspUpdate) state_n = START;
    end else begin
      tick_cnt_n = tick ? '0 : tick_cnt + 1'b1;
      if (tick) s_cnt_n = bit_end ? '0 : s_cnt + 1'b1;
      if (bit_end) begin
        case (state)
          START: begin
            state_n   = DATA;
            bit_idx_n = '0;
          end
          DATA: begin
            if (bit_idx == 3'd7) state_n = STOP;
            else bit_idx_n = bit_idx + 3'd1;
          end
          STOP: begin
            if (byte_idx == 3'(NBYTES - 1)) begin
              state_n   = IDLE;
              last_stop = 1'b1;
            end else begin
              byte_idx_n = byte_idx + 3'd1;
              state_n    = START;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // Outputs are derived from the upcoming state so the line changes on the transition edge
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_n != IDLE);
    done_d = last_stop;
    case (state_n)
      START:   tx_d = 1'b0;
      DATA:    tx_d = pkt[byte_idx_n][bit_idx_n];
      default: tx_d = 1'b1;
    endcase
  end

endmodule
